// File: rtl/fp_add_normalizer.sv
// fp_add_normalizer
//   Post-add normalize-and-round stage for single-precision addition.
//   Takes the raw adder result (sign, biased exponent, extended mantissa
//   with carry/guard/sticky). It normalizes one bit per cycle and rounds
//   to nearest-even. It then packs an IEEE-754 single and raises the
//   status flags.
//
//   Optional feature macro: NORM_FTZ_EN (flush denormal results to zero).
//
//   Ports:
//     clk, rst        clock (rising edge), synchronous active-high reset
//     in_valid/ready  upstream handshake; in_ready high only in IDLE
//     in_sign         result sign
//     in_exp          biased exponent of in_mant[25]; 0 acts as 1
//     in_mant         [26] carry, [25] hidden, [24:2] frac, [1] guard, [0] sticky
//     out_valid/ready downstream handshake; out_valid high in DONE
//     out_data        packed {sign, exp, frac}
//     out_overflow    finite input rounded to infinity
//     out_underflow   denormal result, or flushed result
//     out_inexact     guard or sticky set at rounding
module fp_add_normalizer #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_sign,
   input  logic [EXP_W-1:0]        in_exp,
   input  logic [FRAC_W+3:0]       in_mant,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [EXP_W+FRAC_W:0]   out_data,
   output logic                    out_overflow,
   output logic                    out_underflow,
   output logic                    out_inexact
);

   localparam int C = FRAC_W + 3;   // carry bit position
   localparam int H = FRAC_W + 2;   // hidden bit position
   localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
   localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
   state_t state, state_nx;

   logic                  sign_q;
   logic [EXP_W:0]        exp_q;     // one spare bit so overflow is visible
   logic [FRAC_W+3:0]     mant_q;

   logic                  accept, is_special, is_zero;
   logic [FRAC_W-1:0]     nan_frac;

   // rounding datapath
   logic                  g, s, lsb, up;
   logic [FRAC_W+1:0]     rsum;      // mant[26:2] + round increment
   logic [EXP_W:0]        e_fin;
   logic [FRAC_W-1:0]     f_fin;
   logic [EXP_W+FRAC_W:0] r_data;
   logic                  r_ov, r_uf, r_ix;

   assign accept     = in_valid && (state == IDLE);
   assign is_special = (in_exp == '1);
   assign is_zero    = (in_mant == '0);

   always_comb begin
      nan_frac = in_mant[FRAC_W+1:2];
      if (nan_frac != '0) nan_frac[FRAC_W-1] = 1'b1;
   end

   always_comb begin
      lsb  = mant_q[2];
      g    = mant_q[1];
      s    = mant_q[0];
      up   = g & (s | lsb);
      rsum = mant_q[C:2] + {{(FRAC_W+1){1'b0}}, up};
      // denormal exponent field stays 0 unless rounding reaches the hidden bit
      if (exp_q == '0)
         e_fin = {{EXP_W{1'b0}}, rsum[FRAC_W]};
      else
         e_fin = exp_q + {{EXP_W{1'b0}}, rsum[FRAC_W+1]};
      f_fin  = rsum[FRAC_W+1] ? '0 : rsum[FRAC_W-1:0];
      r_ix   = g | s;
      r_ov   = 1'b0;
      r_uf   = 1'b0;
      r_data = {sign_q, e_fin[EXP_W-1:0], f_fin};
      if (e_fin >= EXP_MAX) begin
         r_data = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
         r_ov   = 1'b1;
         r_ix   = 1'b1;
      end else if (e_fin == '0 && f_fin != '0) begin
`ifdef NORM_FTZ_EN
         r_data = {sign_q, {(EXP_W+FRAC_W){1'b0}}};
         r_ix   = 1'b1;
`endif
         r_uf   = 1'b1;
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (accept) state_nx = (is_special || is_zero) ? DONE : NORM;
         NORM:  if (mant_q[C] || !(mant_q[H] == 1'b0 && exp_q > EXP_ONE))
                   state_nx = ROUND;
         ROUND: state_nx = DONE;
         DONE:  if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // handshake outputs
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // datapath and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         sign_q        <= 1'b0;
         exp_q         <= '0;
         mant_q        <= '0;
         out_data      <= '0;
         out_overflow  <= 1'b0;
         out_underflow <= 1'b0;
         out_inexact   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               sign_q <= in_sign;
               exp_q  <= (in_exp == '0) ? EXP_ONE : {1'b0, in_exp};
               mant_q <= in_mant;
               if (is_special || is_zero) begin
                  out_data      <= is_special ? {in_sign, {EXP_W{1'b1}}, nan_frac}
                                              : {in_sign, {(EXP_W+FRAC_W){1'b0}}};
                  out_overflow  <= 1'b0;
                  out_underflow <= 1'b0;
                  out_inexact   <= 1'b0;
               end
            end
            NORM: begin
               if (mant_q[C]) begin
                  // right shift folds the dropped bit into sticky
                  mant_q <= {1'b0, mant_q[C:2], mant_q[1] | mant_q[0]};
                  exp_q  <= exp_q + EXP_ONE;
               end else if (!mant_q[H] && exp_q > EXP_ONE) begin
                  mant_q <= {mant_q[H:1], 1'b0, mant_q[0]};
                  exp_q  <= exp_q - EXP_ONE;
               end else if (!mant_q[H]) begin
                  exp_q  <= '0;
               end
            end
            ROUND: begin
               out_data      <= r_data;
               out_overflow  <= r_ov;
               out_underflow <= r_uf;
               out_inexact   <= r_ix;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_add_normalizer.sv
module tb_fp_add_normalizer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_sign;
   logic [7:0]  in_exp;
   logic [26:0] in_mant;
   logic        out_valid, out_ready;
   logic [31:0] out_data;
   logic        out_overflow, out_underflow, out_inexact;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fp_add_normalizer #(.EXP_W(8), .FRAC_W(23)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data),
      .out_overflow(out_overflow), .out_underflow(out_underflow),
      .out_inexact(out_inexact)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
      end
   endtask

   // Drives one operation, waits for the result, checks it, optionally
   // holds off out_ready for 'hold' cycles, then completes the handshake.
   // exp_lat < 0 skips the latency check. flags are {ov, uf, ix}.
   task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                         input logic [26:0] m, input logic [31:0] exp_data,
                         input logic [2:0] exp_flags, input int exp_lat,
                         input int hold);
      int n;
      logic [31:0] held;
      check({tag, ":in_ready_idle"}, {31'b0, in_ready}, 32'd1);
      in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, ":out_valid"}, {31'b0, out_valid}, 32'd1);
      if (exp_lat >= 0) check({tag, ":latency"}, n, exp_lat);
      check({tag, ":data"}, out_data, exp_data);
      check({tag, ":flags"}, {29'b0, out_overflow, out_underflow, out_inexact},
            {29'b0, exp_flags});
      check({tag, ":in_ready_busy"}, {31'b0, in_ready}, 32'd0);
      held = out_data;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, ":hold_data"}, out_data, held);
         check({tag, ":hold_valid"}, {31'b0, out_valid}, 32'd1);
         check({tag, ":hold_in_ready"}, {31'b0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, ":valid_drop"}, {31'b0, out_valid}, 32'd0);
      check({tag, ":in_ready_back"}, {31'b0, in_ready}, 32'd1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("reset:out_valid", {31'b0, out_valid}, 32'd0);
      check("reset:in_ready", {31'b0, in_ready}, 32'd1);
      check("reset:data", out_data, 32'h0);
      check("reset:flags", {29'b0, out_overflow, out_underflow, out_inexact}, 32'd0);

      run_op("carry",   1'b0, 8'd127, 27'h4000000, 32'h40000000, 3'b000, 2, 0);
      run_op("cancel",  1'b0, 8'd130, 27'h0100000, 32'h3E800000, 3'b000, 7, 0);
      run_op("rne_tie", 1'b0, 8'd127, 27'h2000002, 32'h3F800000, 3'b001, 2, 0);
      run_op("rne_up",  1'b0, 8'd127, 27'h2000006, 32'h3F800002, 3'b001, 2, 0);
      run_op("ovf",     1'b0, 8'd254, 27'h4000000, 32'h7F800000, 3'b101, 2, 0);
      run_op("nan",     1'b0, 8'd255, 27'h2000004, 32'h7FC00001, 3'b000, -1, 0);
      run_op("inf",     1'b1, 8'd255, 27'h2000000, 32'hFF800000, 3'b000, -1, 0);
      run_op("zero",    1'b1, 8'd100, 27'h0000000, 32'h80000000, 3'b000, -1, 0);
`ifdef NORM_FTZ_EN
      run_op("denorm",  1'b0, 8'd1,   27'h1000000, 32'h00000000, 3'b011, 2, 0);
`else
      run_op("denorm",  1'b0, 8'd1,   27'h1000000, 32'h00400000, 3'b010, 2, 0);
`endif
      // round carry out of the fraction: 1.111..1 + half ulp (lsb odd) -> 2.0
      run_op("rnd_carry", 1'b0, 8'd127, 27'h3FFFFFE, 32'h40000000, 3'b001, 2, 0);
      // denormal that rounds up to the smallest normal
      run_op("dn_to_norm", 1'b0, 8'd0, 27'h1FFFFFE, 32'h00800000, 3'b001, 2, 0);
      run_op("backpress", 1'b1, 8'd128, 27'h2800000, 32'hC0200000, 3'b000, 2, 5);

      // reset in the middle of normalization
      in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd130; in_mant = 27'h0100000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst:out_valid", {31'b0, out_valid}, 32'd0);
      check("midrst:in_ready", {31'b0, in_ready}, 32'd1);
      check("midrst:data", out_data, 32'h0);
      run_op("after_rst", 1'b0, 8'd127, 27'h4000000, 32'h40000000, 3'b000, 2, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
